bch_enc_sched: RTL and testbench

BCH_ENC_SCHED -- requirements
Module: bch_enc_sched

---
 rtl/bch_pkg.sv | 16 +
 rtl/bch_enc_sched_rr_arb2.sv | 34 +++
 rtl/bch_enc_sched.sv | 99 +++++++++
 tb/tb_bch_enc_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared definitions for the BCH encoder scheduling slice.
// Holds the default code geometry (K message bits, N codeword bits), the
// scheduler FSM state type and the width of the encoder-latency counter.
package bch_pkg;

    localparam int unsigned BCH_K = 191;
    localparam int unsigned BCH_N = 255;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_e;

endpackage

// File: rtl/bch_enc_sched_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   req[1:0]  - request lines
//   accept    - strobe: the current grant was taken, advance the pointer
//   grant[1:0]- one-hot grant (all-zero when no request)
// After reset requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Index favoured on a tie; always the one not granted last.
    logic prio;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/bch_enc_sched.sv
// Schedules two message requesters onto one shared bch_encoder instance.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req0_valid/req0_msg      - requester 0 message offer
//   req1_valid/req1_msg      - requester 1 message offer
//   req0_ready/req1_ready    - combinational accept (one cycle, IDLE only)
//   enc_msg                  - registered message to the encoder msg port
//   enc_dataout              - codeword from the encoder bch_dataout port
//   out_valid/out_ready      - codeword handshake towards the consumer
//   out_data/out_src         - captured codeword and owning requester
//   busy                     - high whenever a transaction is in flight
// A grant in cycle t yields out_valid from cycle t+1+ENC_LAT.
module bch_enc_sched
    import bch_pkg::*;
#(
    parameter int unsigned K       = BCH_K,
    parameter int unsigned N       = BCH_N,
    parameter int unsigned ENC_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [K-1:0] req0_msg,
    input  logic         req1_valid,
    input  logic [K-1:0] req1_msg,
    output logic         req0_ready,
    output logic         req1_ready,
    output logic [K-1:0] enc_msg,
    input  logic [N-1:0] enc_dataout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_src,
    output logic         busy
);

    sched_state_e     state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             src_q;
    logic [1:0]       arb_req;
    logic [1:0]       grant;
    logic             granted;

    // Requests only reach the arbiter in IDLE, so readies can never rise
    // elsewhere and never depend on out_ready.
    assign arb_req = (state == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;
    assign granted = |grant;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .accept (granted),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign out_valid  = (state == ST_HOLD);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (granted)              next_state = ST_WAIT;
            ST_WAIT: if (cnt == CNT_W'(1))     next_state = ST_HOLD;
            ST_HOLD: if (out_ready)            next_state = ST_IDLE;
            default:                           next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            enc_msg  <= '0;
            out_data <= '0;
            out_src  <= 1'b0;
            src_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && granted) begin
                enc_msg <= grant[1] ? req1_msg : req0_msg;
                src_q   <= grant[1];
                cnt     <= CNT_W'(ENC_LAT);
            end
            if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
                // out_src is only updated together with out_data so the pair
                // stays consistent while the next message is in the encoder.
                if (cnt == CNT_W'(1)) begin
                    out_data <= enc_dataout;
                    out_src  <= src_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_bch_enc_sched.sv
// Self-checking bench for bch_enc_sched with a behavioural BCH(255,191)
// encoder (generator built from GF(2^8) minimal polynomials, one register
// stage so that ENC_LAT=2 lines up with the scheduler capture point).
module tb_bch_enc_sched;

    localparam int unsigned K       = 191;
    localparam int unsigned N       = 255;
    localparam int unsigned P       = N - K;
    localparam int unsigned ENC_LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [K-1:0] req0_msg, req1_msg;
    logic         req0_ready, req1_ready;
    logic [K-1:0] enc_msg;
    logic [N-1:0] enc_dataout;
    logic         out_valid, out_ready;
    logic [N-1:0] out_data;
    logic         out_src;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [P-1:0] gen;
    int           gf_exp [0:254];
    int           gf_log [0:255];

    bch_enc_sched #(.K(K), .N(N), .ENC_LAT(ENC_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_msg    (req0_msg),
        .req1_valid  (req1_valid),
        .req1_msg    (req1_msg),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .enc_msg     (enc_msg),
        .enc_dataout (enc_dataout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    function automatic int gf_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gf_exp[(gf_log[a] + gf_log[b]) % 255];
    endfunction

    task automatic build_gen();
        int  x;
        int  deg;
        int  g [0:65];
        bit  mark [0:254];
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gf_exp[i] = x;
            gf_log[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        for (int i = 0; i < 255; i++) mark[i] = 1'b0;
        for (int i = 1; i <= 15; i += 2) begin
            int j;
            j = i;
            for (int c = 0; c < 8; c++) begin
                mark[j] = 1'b1;
                j = (j * 2) % 255;
            end
        end
        for (int i = 0; i <= 65; i++) g[i] = 0;
        g[0] = 1;
        deg  = 0;
        for (int j = 0; j < 255; j++) begin
            if (mark[j]) begin
                for (int k = deg + 1; k >= 0; k--) begin
                    g[k] = ((k > 0) ? g[k-1] : 0) ^ gf_mul(g[k], gf_exp[j]);
                end
                deg++;
            end
        end
        for (int b = 0; b < int'(P); b++) gen[b] = g[b][0];
    endtask

    function automatic logic [N-1:0] bch_encode(input logic [K-1:0] m);
        logic [P-1:0] par;
        logic         fb;
        par = '0;
        for (int i = K - 1; i >= 0; i--) begin
            fb  = m[i] ^ par[P-1];
            par = {par[P-2:0], 1'b0};
            if (fb) par = par ^ gen;
        end
        return {m, par};
    endfunction

    always @(posedge clk) enc_dataout <= bch_encode(enc_msg);

    function automatic logic [K-1:0] mk(input logic [63:0] s);
        return K'({s, ~s, s[31:0], s[63:32]});
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from offer to handshake. Offer is driven one unit after
    // a rising edge; readies are sampled one unit later.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [K-1:0] m0, input logic [K-1:0] m1,
                           input bit exp_grant, input bit exp_src, input int hold,
                           input string nm, output logic [N-1:0] data);
        logic [K-1:0] m;
        logic [N-1:0] cw;
        data       = '0;
        req0_valid = v0; req0_msg = m0;
        req1_valid = v1; req1_msg = m1;
        out_ready  = 1'b0;
        #1;
        check({nm, " req0_ready"}, 256'(req0_ready), 256'(exp_grant && !exp_src));
        check({nm, " req1_ready"}, 256'(req1_ready), 256'(exp_grant && exp_src));
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (!exp_grant) begin
            #1;
            check({nm, " idle busy"}, 256'(busy), 256'(0));
            return;
        end
        m  = exp_src ? m1 : m0;
        cw = bch_encode(m);
        #1;
        check({nm, " busy"}, 256'(busy), 256'(1));
        check({nm, " enc_msg"}, 256'(enc_msg), 256'(m));
        check({nm, " early out_valid"}, 256'(out_valid), 256'(0));
        for (int i = 1; i < int'(ENC_LAT); i++) begin
            tick();
            check({nm, " early out_valid"}, 256'(out_valid), 256'(0));
        end
        tick();
        check({nm, " out_valid"}, 256'(out_valid), 256'(1));
        check({nm, " out_data"}, 256'(out_data), 256'(cw));
        check({nm, " out_src"}, 256'(out_src), 256'(exp_src));
        data = out_data;
        for (int i = 0; i < hold; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            check({nm, " hold readies"}, 256'({req1_ready, req0_ready}), 256'(0));
            tick();
            check({nm, " hold out_valid"}, 256'(out_valid), 256'(1));
            check({nm, " hold busy"}, 256'(busy), 256'(1));
            check({nm, " hold out_data"}, 256'(out_data), 256'(cw));
            check({nm, " hold out_src"}, 256'(out_src), 256'(exp_src));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, " done out_valid"}, 256'(out_valid), 256'(0));
        check({nm, " done busy"}, 256'(busy), 256'(0));
    endtask

    typedef struct {
        bit           v0;
        bit           v1;
        logic [K-1:0] m0;
        logic [K-1:0] m1;
        bit           exp_grant;
        bit           exp_src;
        int           hold;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [N-1:0] d, da, db, dab;
        logic [K-1:0] ma, mb, ones;
        int           g_cnt, o_cnt, last_g;
        int           g_cyc [$];
        bit           g_src [$];
        bit           o_src [$];
        logic [N-1:0] o_dat [$];

        build_gen();
        ones = '1;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_msg = '0; req1_msg = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset out_valid", 256'(out_valid), 256'(0));
        check("reset readies", 256'({req1_ready, req0_ready}), 256'(0));
        check("reset busy", 256'(busy), 256'(0));
        check("reset enc_msg", 256'(enc_msg), 256'(0));
        check("reset out_data", 256'(out_data), 256'(0));
        check("reset out_src", 256'(out_src), 256'(0));
        repeat (7) tick();

        //           v0    v1    m0                         m1                         grant src hold
        vecs[0] = '{1'b1, 1'b0, '0,                        mk(64'h1111_2222_3333_4444), 1'b1, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b1, mk(64'h5555_6666_7777_8888), mk(64'h0123_4567_89AB_CDEF), 1'b1, 1'b1, 1};
        vecs[2] = '{1'b1, 1'b1, mk(64'hDEAD_BEEF_0000_0001), mk(64'hFEED_FACE_CAFE_F00D), 1'b1, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b1, mk(64'hA5A5_A5A5_5A5A_5A5A), mk(64'h8000_0000_0000_0001), 1'b1, 1'b1, 2};
        vecs[4] = '{1'b0, 1'b0, mk(64'h1234_0000_0000_4321), mk(64'h9999_9999_9999_9999), 1'b0, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b1, mk(64'h0F0F_0F0F_F0F0_F0F0), mk(64'h3C3C_3C3C_C3C3_C3C3), 1'b1, 1'b0, 0};
        vecs[6] = '{1'b0, 1'b1, mk(64'h7777_0000_1111_2222), mk(64'h0000_0000_0000_0080), 1'b1, 1'b1, 3};
        vecs[7] = '{1'b1, 1'b0, mk(64'h2468_ACE0_1357_9BDF), mk(64'hBBBB_CCCC_DDDD_EEEE), 1'b1, 1'b0, 0};
        vecs[8] = '{1'b1, 1'b1, ones,                        mk(64'h6666_1234_5678_9ABC), 1'b1, 1'b1, 0};
        vecs[9] = '{1'b1, 1'b0, ones,                        mk(64'h4242_4242_4242_4242), 1'b1, 1'b0, 0};

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].v0, vecs[i].v1, vecs[i].m0, vecs[i].m1,
                    vecs[i].exp_grant, vecs[i].exp_src, vecs[i].hold,
                    $sformatf("vec%0d", i), d);
        end
        check("all-ones codeword", 256'(d), 256'(bch_encode(ones)));

        // Backpressure: 20 cycles in HOLD with out_ready low (req1 owns it).
        run_txn(1'b0, 1'b1, '0, mk(64'hC0DE_C0DE_1357_2468), 1'b1, 1'b1, 20, "backpressure", d);

        // Linearity of captured codewords.
        ma = mk(64'h0BAD_F00D_DEAD_10CC);
        mb = mk(64'h7331_7331_ABCD_EF01);
        run_txn(1'b1, 1'b0, ma, '0, 1'b1, 1'b0, 0, "lin a", da);
        run_txn(1'b1, 1'b0, mb, '0, 1'b1, 1'b0, 0, "lin b", db);
        run_txn(1'b1, 1'b0, ma ^ mb, '0, 1'b1, 1'b0, 0, "lin ab", dab);
        check("linearity", 256'(da ^ db), 256'(dab));

        // Reset one cycle after a req0 grant: transaction abandoned.
        req0_valid = 1'b1; req0_msg = mk(64'h5151_5151_2626_2626);
        #1;
        check("rst grant req0", 256'(req0_ready), 256'(1));
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midwait rst out_valid", 256'(out_valid), 256'(0));
        check("midwait rst busy", 256'(busy), 256'(0));
        check("midwait rst enc_msg", 256'(enc_msg), 256'(0));
        check("midwait rst out_data", 256'(out_data), 256'(0));
        check("midwait rst out_src", 256'(out_src), 256'(0));
        g_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) g_cnt++;
        end
        check("midwait no out_valid", 256'(g_cnt), 256'(0));

        // Continuous tie with out_ready held high.
        req0_msg = mk(64'hAAAA_0000_AAAA_0000);
        req1_msg = mk(64'h0000_BBBB_0000_BBBB);
        req0_valid = 1'b1; req1_valid = 1'b1;
        out_ready  = 1'b1;
        #1;
        check("tie after reset req0", 256'({req1_ready, req0_ready}), 256'(2'b01));
        g_cnt = 0; o_cnt = 0;
        for (int cyc = 0; cyc < 60 && o_cnt < 4; cyc++) begin
            if (req0_ready || req1_ready) begin
                g_cyc.push_back(cyc);
                g_src.push_back(req1_ready);
                g_cnt++;
            end
            if (out_valid) begin
                o_src.push_back(out_src);
                o_dat.push_back(out_data);
                o_cnt++;
            end
            tick();
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        check("tie outputs seen", 256'(o_cnt), 256'(4));
        last_g = -1;
        for (int i = 0; i < 4 && i < g_cnt && i < o_cnt; i++) begin
            check($sformatf("tie grant%0d", i), 256'(g_src[i]), 256'(i % 2));
            check($sformatf("tie src%0d", i), 256'(o_src[i]), 256'(i % 2));
            check($sformatf("tie data%0d", i), 256'(o_dat[i]),
                  256'(bch_encode((i % 2) ? req1_msg : req0_msg)));
            if (last_g >= 0)
                check($sformatf("tie spacing%0d", i), 256'(g_cyc[i] - last_g), 256'(ENC_LAT + 2));
            last_g = g_cyc[i];
        end

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
